// File: rtl/tlb_flush_ctrl_pkg.sv
// Shared types for the SFENCE TLB flush controller: the TLB tag layout,
// the controller state encoding and the VPN field constants.
package tlb_flush_ctrl_pkg;

  localparam int VPN_W       = 20;
  localparam int VPN_MEGA_LO = 10;
  localparam int TAG_ASID_W  = 9;

  // Tag as returned by each TLB read port (valid is the MSB).
  typedef struct packed {
    logic                  valid;
    logic                  is_global;
    logic                  mega;
    logic [TAG_ASID_W-1:0] asid;
    logic [VPN_W-1:0]      vpn;
  } tlb_tag_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_WALK  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } flush_state_e;

  // A megapage only pins the upper VPN field, so the low field is a don't-care.
  function automatic logic vpn_hit(input logic [VPN_W-1:0] tag_vpn,
                                   input logic [VPN_W-1:0] req_vpn,
                                   input logic             mega);
    logic hit_s;
    if (mega) begin
      hit_s = (tag_vpn[VPN_W-1:VPN_MEGA_LO] == req_vpn[VPN_W-1:VPN_MEGA_LO]);
    end else begin
      hit_s = (tag_vpn == req_vpn);
    end
    return hit_s;
  endfunction

endpackage

// File: rtl/tlb_flush_ctrl_tag_match.sv
// Decides whether one returned TLB tag is hit by the captured SFENCE request.
// Optional build macro HARVOS_SFENCE_ASID_EN: when defined the ASID is
// honoured; when undefined every ASID matches (flushes a superset).
module tlb_tag_match
  import tlb_flush_ctrl_pkg::*;
#(
  parameter int ASID_W = 9
) (
  input  tlb_tag_t          tag,
  input  logic              addr_valid,
  input  logic [VPN_W-1:0]  req_vpn,
  input  logic              asid_valid,
  input  logic [ASID_W-1:0] req_asid,
  output logic              match
);

  logic addr_term_s;
  logic asid_term_s;

`ifndef HARVOS_SFENCE_ASID_EN
  // ASID fields are intentionally ignored in this build.
  logic unused_asid_s;
  assign unused_asid_s = ^{asid_valid, req_asid, tag.is_global, tag.asid};
`endif

  // Combine valid bit, address term and ASID term into the match decision.
  always_comb begin
    addr_term_s = 1'b1;
    asid_term_s = 1'b1;
    match       = 1'b0;
    if (addr_valid) begin
      addr_term_s = vpn_hit(tag.vpn, req_vpn, tag.mega);
    end else begin
      addr_term_s = 1'b1;
    end
`ifdef HARVOS_SFENCE_ASID_EN
    if (asid_valid) begin
      asid_term_s = !tag.is_global && (tag.asid[ASID_W-1:0] == req_asid);
    end else begin
      asid_term_s = 1'b1;
    end
`else
    asid_term_s = 1'b1;
`endif
    match = tag.valid && addr_term_s && asid_term_s;
  end

endmodule

// File: rtl/tlb_flush_ctrl.sv
// SFENCE flush controller for an iTLB/dTLB pair: either bulk-invalidates both
// TLBs in one cycle or walks every index, comparing the returned tags and
// invalidating matching entries one cycle after each read.
// Optional build macro HARVOS_SFENCE_ASID_EN selects ASID-qualified matching.
module tlb_flush_ctrl
  import tlb_flush_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ASID_W  = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_flush_all,
  input  logic                       req_addr_valid,
  input  logic [31:0]                req_vaddr,
  input  logic                       req_asid_valid,
  input  logic [15:0]                req_asid,
  output logic [$clog2(ENTRIES)-1:0] tlb_rd_idx,
  input  tlb_tag_t                   itlb_rd_tag,
  input  tlb_tag_t                   dtlb_rd_tag,
  output logic                       itlb_inval,
  output logic                       dtlb_inval,
  output logic [$clog2(ENTRIES)-1:0] inval_idx,
  output logic                       tlb_flush_all,
  output logic                       busy,
  output logic                       done
);

  localparam int                IDX_W    = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  flush_state_e      state_q, state_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [IDX_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic              addr_valid_q, addr_valid_d;
  logic [VPN_W-1:0]  vpn_q, vpn_d;
  logic              asid_valid_q, asid_valid_d;
  logic [ASID_W-1:0] asid_q, asid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              flush_all_q, flush_all_d;
  logic              done_q, done_d;

  logic              accept_s;
  logic              bulk_s;
  logic              itlb_match_s;
  logic              dtlb_match_s;

  // Page offset and ASID bits above ASID_W never take part in matching.
  logic unused_req_bits_s;
  assign unused_req_bits_s = ^{req_vaddr[11:0], req_asid[15:ASID_W]};

  assign accept_s = req_valid && req_ready_q;
  assign bulk_s   = req_flush_all || (!req_addr_valid && !req_asid_valid);

  // Next-state, request capture, walk index and registered strobe decode.
  always_comb begin
    state_d      = state_q;
    rd_idx_d     = {IDX_W{1'b0}};
    addr_valid_d = addr_valid_q;
    vpn_d        = vpn_q;
    asid_valid_d = asid_valid_q;
    asid_d       = asid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_valid_d = req_addr_valid;
          vpn_d        = req_vaddr[31:12];
          asid_valid_d = req_asid_valid;
          asid_d       = req_asid[ASID_W-1:0];
          if (bulk_s) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_WALK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_WALK: begin
        if (rd_idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // The compare stage trails the read index by one cycle.
    cmp_valid_d = (state_q == ST_WALK);
    if (state_q == ST_WALK) begin
      cmp_idx_d = rd_idx_q;
    end else begin
      cmp_idx_d = {IDX_W{1'b0}};
    end
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    flush_all_d = (state_d == ST_FLUSH);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any flush in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_idx_q     <= {IDX_W{1'b0}};
      cmp_valid_q  <= 1'b0;
      cmp_idx_q    <= {IDX_W{1'b0}};
      addr_valid_q <= 1'b0;
      vpn_q        <= {VPN_W{1'b0}};
      asid_valid_q <= 1'b0;
      asid_q       <= {ASID_W{1'b0}};
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      flush_all_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_idx_q    <= cmp_idx_d;
      addr_valid_q <= addr_valid_d;
      vpn_q        <= vpn_d;
      asid_valid_q <= asid_valid_d;
      asid_q       <= asid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      flush_all_q  <= flush_all_d;
      done_q       <= done_d;
    end
  end

  tlb_tag_match #(.ASID_W(ASID_W)) u_itlb_match (
    .tag        (itlb_rd_tag),
    .addr_valid (addr_valid_q),
    .req_vpn    (vpn_q),
    .asid_valid (asid_valid_q),
    .req_asid   (asid_q),
    .match      (itlb_match_s)
  );

  tlb_tag_match #(.ASID_W(ASID_W)) u_dtlb_match (
    .tag        (dtlb_rd_tag),
    .addr_valid (addr_valid_q),
    .req_vpn    (vpn_q),
    .asid_valid (asid_valid_q),
    .req_asid   (asid_q),
    .match      (dtlb_match_s)
  );

  // Invalidates respond to the tag read one cycle earlier, so they are
  // qualified by the registered compare stage rather than re-registered.
  assign itlb_inval    = cmp_valid_q && itlb_match_s;
  assign dtlb_inval    = cmp_valid_q && dtlb_match_s;
  assign inval_idx     = cmp_idx_q;
  assign tlb_rd_idx    = rd_idx_q;
  assign tlb_flush_all = flush_all_q;
  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_tlb_flush_ctrl.sv
// Self-checking bench for tlb_flush_ctrl (ENTRIES=16). Expected strobes are
// queued when a request is accepted and popped as the DUT produces them.
module tb_tlb_flush_ctrl;
  import tlb_flush_ctrl_pkg::*;

  localparam int ENT = 16;
  localparam int K_FLUSH = 0, K_ITLB = 1, K_DTLB = 2, K_DONE = 3;

  typedef struct {
    int kind;
    int cyc;
    int idx;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_flush_all, req_addr_valid, req_asid_valid;
  logic [31:0] req_vaddr;
  logic [15:0] req_asid;
  logic [3:0]  tlb_rd_idx, inval_idx;
  tlb_tag_t    itlb_rd_tag, dtlb_rd_tag;
  logic        itlb_inval, dtlb_inval, tlb_flush_all, busy, done;

  tlb_tag_t itags [ENT];
  tlb_tag_t dtags [ENT];
  ev_t      exp_q [$];
  int       cyc = 0;
  int       n_cmp = 0;
  int       n_fail = 0;
  int       walk_t = -100;
  int       walk_last = -100;
  bit       mon_en = 1'b0;

  tlb_flush_ctrl #(.ENTRIES(ENT), .ASID_W(9)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_flush_all(req_flush_all), .req_addr_valid(req_addr_valid),
    .req_vaddr(req_vaddr), .req_asid_valid(req_asid_valid), .req_asid(req_asid),
    .tlb_rd_idx(tlb_rd_idx), .itlb_rd_tag(itlb_rd_tag), .dtlb_rd_tag(dtlb_rd_tag),
    .itlb_inval(itlb_inval), .dtlb_inval(dtlb_inval), .inval_idx(inval_idx),
    .tlb_flush_all(tlb_flush_all), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read TLB model: the tag appears the cycle after the index.
  always @(posedge clk) begin
    itlb_rd_tag <= itags[tlb_rd_idx];
    dtlb_rd_tag <= dtags[tlb_rd_idx];
  end

  function automatic tlb_tag_t mk(input bit v, input bit g, input bit m,
                                  input logic [8:0] a, input logic [19:0] vpn);
    tlb_tag_t t;
    t.valid = v; t.is_global = g; t.mega = m; t.asid = a; t.vpn = vpn;
    return t;
  endfunction

  // Reference match rule written from the requirement text.
  function automatic bit ref_match(input tlb_tag_t t, input bit av, input logic [31:0] va,
                                   input bit asv, input logic [15:0] as);
    bit a_ok, s_ok;
    if (!av) a_ok = 1'b1;
    else if (t.mega) a_ok = (t.vpn[19:10] == va[31:22]);
    else a_ok = (t.vpn == va[31:12]);
`ifdef HARVOS_SFENCE_ASID_EN
    s_ok = !asv || (!t.is_global && (t.asid == as[8:0]));
`else
    s_ok = 1'b1;
`endif
    return t.valid && a_ok && s_ok;
  endfunction

  task automatic clear_tlbs();
    for (int i = 0; i < ENT; i++) begin
      itags[i] = mk(1'b0, 1'b0, 1'b0, 9'h0, 20'h0);
      dtags[i] = mk(1'b0, 1'b0, 1'b0, 9'h0, 20'h0);
    end
  endtask

  task automatic check_ev(input int kind, input int idx);
    ev_t e;
    n_cmp++;
    assert (exp_q.size() != 0)
    else begin
      n_fail++;
      $error("FAIL stray_strobe kind=%0d idx=%0d cyc=%0d expected no strobe", kind, idx, cyc);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (e.kind === kind && e.cyc === cyc && e.idx === idx)
      else begin
        n_fail++;
        $error("FAIL strobe got kind=%0d cyc=%0d idx=%0d expected kind=%0d cyc=%0d idx=%0d",
               kind, cyc, idx, e.kind, e.cyc, e.idx);
      end
    end
  endtask

  // Monitor: every strobe must match the head of the queue; read index follows the walk window.
  always @(negedge clk) begin
    int exp_rd;
    if (mon_en) begin
      if (tlb_flush_all === 1'b1) check_ev(K_FLUSH, 0);
      if (itlb_inval === 1'b1) check_ev(K_ITLB, int'(inval_idx));
      if (dtlb_inval === 1'b1) check_ev(K_DTLB, int'(inval_idx));
      if (done === 1'b1) check_ev(K_DONE, 0);
      exp_rd = (cyc >= walk_t + 1 && cyc <= walk_last) ? cyc - walk_t - 1 : 0;
      n_cmp++;
      assert (tlb_rd_idx === exp_rd[3:0])
      else begin
        n_fail++;
        $error("FAIL rd_idx cyc=%0d got %0d expected %0d", cyc, tlb_rd_idx, exp_rd);
      end
    end
  end

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s got %b expected %b", tag, obs, expv);
    end
  endtask

  // Present a request at a negedge, wait for acceptance, queue expected strobes.
  task automatic send(input bit fa, input bit av, input logic [31:0] va, input bit asv,
                      input logic [15:0] as, input int abort_off, input bit keep,
                      output int t_acc);
    int waited = 0;
    int c;
    req_flush_all = fa; req_addr_valid = av; req_vaddr = va;
    req_asid_valid = asv; req_asid = as; req_valid = 1'b1;
    while (req_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    assert (waited < 40)
    else begin
      n_fail++;
      $error("FAIL accept_timeout waited %0d cycles expected under 40", waited);
    end
    t_acc = cyc;
    if (fa || (!av && !asv)) begin
      exp_q.push_back('{K_FLUSH, t_acc + 1, 0});
      exp_q.push_back('{K_DONE, t_acc + 2, 0});
    end else begin
      walk_t = t_acc;
      walk_last = (abort_off != 0) ? t_acc + abort_off : t_acc + ENT;
      for (int i = 0; i < ENT; i++) begin
        c = t_acc + 2 + i;
        if (abort_off == 0 || c <= t_acc + abort_off) begin
          if (ref_match(itags[i], av, va, asv, as)) exp_q.push_back('{K_ITLB, c, i});
          if (ref_match(dtags[i], av, va, asv, as)) exp_q.push_back('{K_DTLB, c, i});
        end
      end
      if (abort_off == 0) exp_q.push_back('{K_DONE, t_acc + ENT + 2, 0});
    end
    @(negedge clk);
    if (!keep) begin
      req_valid = 1'b0; req_flush_all = 1'b0; req_addr_valid = 1'b1;
      req_vaddr = 32'hFFFF_F000; req_asid_valid = 1'b1; req_asid = 16'h01FF;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && w < 60) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    assert (exp_q.size() == 0 && w < 60)
    else begin
      n_fail++;
      $error("FAIL drain pending=%0d waited=%0d expected 0 pending", exp_q.size(), w);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t1, t2;
    rst = 1'b1; req_valid = 1'b0; req_flush_all = 1'b0; req_addr_valid = 1'b0;
    req_vaddr = 32'h0; req_asid_valid = 1'b0; req_asid = 16'h0;
    clear_tlbs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_ready", req_ready, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_strobes", itlb_inval | dtlb_inval | tlb_flush_all, 1'b0);
    check_bit("rst_idx_zero", (tlb_rd_idx == 4'd0) && (inval_idx == 4'd0), 1'b1);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Bulk flush via flush_all with populated TLBs: no per-entry invalidates.
    itags[4] = mk(1'b1, 1'b0, 1'b0, 9'h2A, 20'h00403);
    send(1'b1, 1'b1, 32'h0040_3000, 1'b0, 16'h0, 0, 1'b0, t1);
    wait_idle();

    // Address-only: iTLB entry 5 hits, invalid dTLB entry with same VPN does not.
    clear_tlbs();
    itags[5] = mk(1'b1, 1'b0, 1'b0, 9'h11, 20'h00403);
    itags[6] = mk(1'b1, 1'b0, 1'b0, 9'h11, 20'h00404);
    dtags[2] = mk(1'b0, 1'b0, 1'b0, 9'h11, 20'h00403);
    dtags[5] = mk(1'b1, 1'b0, 1'b0, 9'h11, 20'h00404);
    send(1'b0, 1'b1, 32'h0040_3000, 1'b0, 16'h0, 0, 1'b0, t1);
    check_bit("walk_busy", busy, 1'b1);
    check_bit("walk_not_ready", req_ready, 1'b0);
    wait_idle();

    // ASID-only: global entry spared only when ASID handling is enabled.
    clear_tlbs();
    dtags[3] = mk(1'b1, 1'b0, 1'b0, 9'h02A, 20'h12345);
    dtags[9] = mk(1'b1, 1'b1, 1'b0, 9'h02A, 20'h00777);
    dtags[6] = mk(1'b1, 1'b0, 1'b0, 9'h02B, 20'h00001);
    send(1'b0, 1'b0, 32'h0, 1'b1, 16'hFE2A, 0, 1'b0, t1);
    wait_idle();

    // Megapage compares VPN[19:10] only; boundary indices 0 and 15 included.
    clear_tlbs();
    itags[7]  = mk(1'b1, 1'b0, 1'b1, 9'h0, 20'h00512);
    itags[0]  = mk(1'b1, 1'b0, 1'b1, 9'h0, 20'h005FF);
    itags[15] = mk(1'b1, 1'b0, 1'b1, 9'h0, 20'h00400);
    dtags[7]  = mk(1'b1, 1'b0, 1'b0, 9'h0, 20'h00512);
    dtags[15] = mk(1'b1, 1'b0, 1'b0, 9'h0, 20'h00500);
    send(1'b0, 1'b1, 32'h0050_0000, 1'b0, 16'h0, 0, 1'b0, t1);
    wait_idle();

    // Back-to-back: req_valid held, second (address+ASID) request waits for ready.
    clear_tlbs();
    itags[5] = mk(1'b1, 1'b0, 1'b0, 9'h11, 20'h00403);
    dtags[1] = mk(1'b1, 1'b0, 1'b0, 9'h33, 20'h00403);
    dtags[8] = mk(1'b1, 1'b0, 1'b0, 9'h34, 20'h00403);
    send(1'b0, 1'b1, 32'h0040_3000, 1'b0, 16'h0, 0, 1'b1, t1);
    check_bit("b2b_not_ready", req_ready, 1'b0);
    send(1'b0, 1'b1, 32'h0040_3ABC, 1'b1, 16'h0033, 0, 1'b0, t2);
    n_cmp++;
    assert (t2 === t1 + 19)
    else begin
      n_fail++;
      $error("FAIL b2b_accept got T+%0d expected T+19", t2 - t1);
    end
    wait_idle();

    // Reset at T+6 mid-walk: entry 2 invalidates, entry 10 must not, no done.
    clear_tlbs();
    itags[2]  = mk(1'b1, 1'b0, 1'b0, 9'h0, 20'h00403);
    itags[10] = mk(1'b1, 1'b0, 1'b0, 9'h0, 20'h00403);
    dtags[12] = mk(1'b1, 1'b0, 1'b0, 9'h0, 20'h00403);
    send(1'b0, 1'b1, 32'h0040_3000, 1'b0, 16'h0, 6, 1'b0, t1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_bit("abort_ready", req_ready, 1'b1);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    repeat (20) @(negedge clk);
    wait_idle();

    // Bulk flush implied by neither address nor ASID being valid.
    itags[3] = mk(1'b1, 1'b0, 1'b0, 9'h0, 20'h00403);
    send(1'b0, 1'b0, 32'h0040_3000, 1'b0, 16'h0, 0, 1'b0, t1);
    wait_idle();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d expected completion earlier", cyc);
    $fatal(1, "timeout");
  end

endmodule
